residue_predict_compare: RTL
============================

Name: residue_predict_compare

Overview:
- Generates the predicted residue (mod 2^MOD_BITS) of each functional-unit operation from its operands.
- Queues predictions until the matching observed residue arrives from the downstream residue checker, then compares them.
- Flags mismatches, maintains a sticky fault state and a saturating error count.
- Sits beside the functional unit, paired with the checker on the unit's output.

Parameters:
- MOD_BITS, 16, residue modulus is 2^MOD_BITS; legal range 1..16.
- FIFO_DEPTH, 4, outstanding predictions held; power of two, 2..16.

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst_n  input  1  asynchronous active-low reset
- chk_enable  input  1  1 = checking active; 0 = flush and idle
- op_valid  input  1  operation issued this cycle
- op_code  input  2  0=ADD, 1=SUB, 2=MUL, 3=PASS (result = operand_a)
- operand_a  input  16  first operand
- operand_b  input  16  second operand
- res_valid  input  1  observed residue valid this cycle
- res_in  input  16  observed residue from checker; bits above MOD_BITS ignored
- clr_err  input  1  clear sticky fault and error count
- err_pulse  output  1  one-cycle mismatch indication
- err_sticky  output  1  high while in FAULT
- err_count  output  8  saturating mismatch count
- proto_err  output  1  sticky: FIFO overflow or underflow seen
- exp_residue  output  16  last compared predicted residue, zero-extended

Behaviour:
- Reset (async, rst_n=0): all outputs 0; FIFO empty; state DISABLED.
- Prediction (combinational, then pushed):
  - ra = a mod 2^MOD_BITS, rb = b mod 2^MOD_BITS.
  - ADD: (ra+rb); SUB: (ra-rb), two's-complement wrap; MUL: (ra*rb); PASS: ra.
  - Each result masked to MOD_BITS.
- Push: op_valid=1 and state != DISABLED pushes the prediction at that clock edge.
- Pop/compare:
  - res_valid=1 with FIFO non-empty pops the head and compares it with res_in[MOD_BITS-1:0].
  - exp_residue is updated to the head value at the same edge.
  - On mismatch: err_pulse=1 the following cycle only; err_count += 1, saturating at 255.
- Latency: earliest compare is the cycle after the push (no same-cycle bypass through an empty FIFO).
- FIFO boundaries:
  - Push+pop in the same cycle is legal at any occupancy, including full; count is unchanged.
  - Push when full without a pop: prediction dropped, proto_err set.
  - res_valid while empty: no compare, no err_pulse, proto_err set.
- State machine:
  - DISABLED: no push, no pop, FIFO held empty. chk_enable=1 -> RUN.
  - RUN: mismatch -> FAULT.
  - FAULT: err_sticky=1; pushes, compares and counting continue. clr_err=1 -> RUN.
  - Any state: chk_enable=0 -> DISABLED. This flushes the FIFO but keeps err_count, proto_err and err_sticky.
- clr_err:
  - Zeroes err_count and proto_err, and moves FAULT -> RUN, at the next edge.
  - If a mismatch is compared in the same cycle, the mismatch wins: err_count=1 and the state is FAULT.
- Reset mid-operation discards all queued predictions immediately (async).

Decomposition:
- Shared package: op_code constants (OP_ADD, OP_SUB, OP_MUL, OP_PASS); state encoding (ST_DISABLED, ST_RUN, ST_FAULT); ERR_CNT_W=8.
- Sub-module residue_fifo: synchronous FIFO with parameterised width and depth, flush input, full/empty outputs, and async active-low reset on clk/rst_n.
- Prediction arithmetic and state machine live in the top module.

Test Plan:
1. MOD_BITS=4, enable; ADD a=0x0013 b=0x0025 then res_in=0x0008 -> err_pulse stays 0, exp_residue=0x0008, state RUN.
2. Same ADD with res_in=0x0009 -> err_pulse=1 for one cycle, err_count=1, err_sticky=1; then clr_err -> err_count=0, err_sticky=0.
3. MOD_BITS=4: SUB a=2 b=5 expects 0xD; MUL a=7 b=3 expects 0x5; PASS a=0xFFFA expects 0xA. Issue back-to-back with in-order residues -> no errors.
4. FIFO_DEPTH=4:
   - 5 pushes, no pops -> 5th dropped, proto_err=1.
   - Then push+pop at full -> occupancy stays 4.
   - Then res_valid with empty FIFO -> proto_err set, no err_pulse.
5. 300 consecutive mismatches -> err_count saturates at 255. Drop chk_enable -> FIFO empty, err_count still 255.
6. Assert rst_n=0 mid-stream with 3 queued predictions -> outputs 0 immediately, without waiting for a clock edge. After release, res_valid -> proto_err (FIFO empty).

Source files
------------

// File: rtl/residue_predict_compare_pkg.sv
// Shared constants and types for the residue predict/compare block.
package residue_predict_compare_pkg;

    // Functional-unit operation codes
    localparam logic [1:0] OP_ADD  = 2'd0;
    localparam logic [1:0] OP_SUB  = 2'd1;
    localparam logic [1:0] OP_MUL  = 2'd2;
    localparam logic [1:0] OP_PASS = 2'd3;

    // Width of the saturating mismatch counter
    localparam int ERR_CNT_W = 8;

    typedef enum logic [1:0] {
        ST_DISABLED = 2'd0,
        ST_RUN      = 2'd1,
        ST_FAULT    = 2'd2
    } state_e;

endpackage

// File: rtl/residue_fifo.sv
// Synchronous FIFO holding predicted residues until the observed value arrives.
// A push at full is accepted only when a pop frees a slot in the same cycle;
// a pop while empty is ignored. Flush empties the FIFO at the next edge.
module residue_fifo #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // Pointers carry one extra wrap bit to tell full from empty
    logic [AW:0]      r_wptr;
    logic [AW:0]      r_rptr;
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic             w_do_pop;
    logic             w_do_push;

    assign empty     = (r_wptr == r_rptr);
    assign full      = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign w_do_pop  = pop && !empty;
    assign w_do_push = push && (!full || w_do_pop);
    assign rdata     = r_mem[r_rptr[AW-1:0]];

    // Pointer update; flush discards everything queued
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else if (flush) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + 1'b1;
            if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
        end
    end

    // Storage write; contents need no reset since the pointers gate reads
    always_ff @(posedge clk) begin
        if (w_do_push && !flush) r_mem[r_wptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/residue_predict_compare.sv
// Predicts the residue mod 2^MOD_BITS of each issued operation, queues it, and
// compares it against the residue later reported by the output-side checker.
module residue_predict_compare
    import residue_predict_compare_pkg::*;
#(
    parameter int unsigned MOD_BITS   = 16,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 chk_enable,
    input  logic                 op_valid,
    input  logic [1:0]           op_code,
    input  logic [15:0]          operand_a,
    input  logic [15:0]          operand_b,
    input  logic                 res_valid,
    input  logic [15:0]          res_in,
    input  logic                 clr_err,
    output logic                 err_pulse,
    output logic                 err_sticky,
    output logic [ERR_CNT_W-1:0] err_count,
    output logic                 proto_err,
    output logic [15:0]          exp_residue
);

    localparam logic [15:0] MASK = 16'((32'd1 << MOD_BITS) - 32'd1);

    state_e               r_state;
    logic                 r_err_pulse;
    logic                 r_err_sticky;
    logic [ERR_CNT_W-1:0] r_err_count;
    logic                 r_proto_err;
    logic [15:0]          r_exp_residue;

    logic [15:0] w_ra;
    logic [15:0] w_rb;
    logic [15:0] w_raw;
    logic [15:0] w_pred;
    logic [15:0] w_head;
    logic [15:0] w_obs;
    logic        w_full;
    logic        w_empty;
    logic        w_active;
    logic        w_push;
    logic        w_pop;
    logic        w_compare;
    logic        w_mismatch;
    logic        w_proto_set;
    logic        w_sticky_d;

    // 16-bit wrap-around arithmetic is exact mod 2^MOD_BITS since MOD_BITS <= 16
    assign w_ra = operand_a & MASK;
    assign w_rb = operand_b & MASK;

    // Operation decode for the predicted result
    always_comb begin
        w_raw = w_ra;
        case (op_code)
            OP_ADD:  w_raw = w_ra + w_rb;
            OP_SUB:  w_raw = w_ra - w_rb;
            OP_MUL:  w_raw = w_ra * w_rb;
            default: w_raw = w_ra;
        endcase
    end

    assign w_pred = w_raw & MASK;
    assign w_obs  = res_in & MASK;

    // Pushes and pops only while enabled and already out of DISABLED
    assign w_active    = chk_enable && (r_state != ST_DISABLED);
    assign w_push      = w_active && op_valid;
    assign w_pop       = w_active && res_valid;
    assign w_compare   = w_pop && !w_empty;
    assign w_mismatch  = w_compare && (w_head != w_obs);
    // Overflow: full with no pop to make room. Underflow: residue with nothing queued.
    assign w_proto_set = w_active && ((res_valid && w_empty) || (op_valid && w_full && !res_valid));
    // A mismatch in the same cycle as clr_err wins
    assign w_sticky_d  = w_mismatch ? 1'b1 : (clr_err ? 1'b0 : r_err_sticky);

    residue_fifo #(
        .WIDTH (16),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (!w_active),
        .push  (w_push),
        .pop   (w_pop),
        .wdata (w_pred),
        .rdata (w_head),
        .full  (w_full),
        .empty (w_empty)
    );

    // Control state machine with registered error outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_DISABLED;
            r_err_pulse   <= 1'b0;
            r_err_sticky  <= 1'b0;
            r_err_count   <= '0;
            r_proto_err   <= 1'b0;
            r_exp_residue <= '0;
        end else begin
            r_err_pulse  <= w_mismatch;
            r_err_sticky <= w_sticky_d;
            if (w_compare) r_exp_residue <= w_head;

            if (w_mismatch) begin
                if (clr_err)                 r_err_count <= ERR_CNT_W'(1);
                else if (r_err_count != '1)  r_err_count <= r_err_count + 1'b1;
            end else if (clr_err) begin
                r_err_count <= '0;
            end

            if (w_proto_set)  r_proto_err <= 1'b1;
            else if (clr_err) r_proto_err <= 1'b0;

            // Re-enabling with an uncleared fault resumes in FAULT
            if (!chk_enable)     r_state <= ST_DISABLED;
            else if (w_sticky_d) r_state <= ST_FAULT;
            else                 r_state <= ST_RUN;
        end
    end

    assign err_pulse   = r_err_pulse;
    assign err_sticky  = r_err_sticky;
    assign err_count   = r_err_count;
    assign proto_err   = r_proto_err;
    assign exp_residue = r_exp_residue;

endmodule
